// File: rtl/pretu_pkg.sv
// Shared constants for the pre-transform tile loader.
package pretu_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned TILE_N     = 4;
    localparam int unsigned TILE_ELEMS = TILE_N * TILE_N;
    localparam int unsigned IDX_W      = 4;

    // Fill index of the final element of a tile.
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TILE_ELEMS - 1);

endpackage

// File: rtl/pretu_tile_reg.sv
// One 16-element tile storage bank, element i held at tile_o[i*DW +: DW].
// Contents clear on reset; a single element is written per cycle.
module pretu_tile_reg
    import pretu_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         waddr_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [TILE_ELEMS*DW-1:0] tile_o
);

    logic [TILE_ELEMS*DW-1:0] mem_q, mem_d;

    // Next-state: overwrite the addressed element when written.
    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[int'(waddr_i) * DW +: DW] = wdata_i;
        end
    end

    // Bank storage with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign tile_o = mem_q;

endmodule

// File: rtl/pretu_tile_loader.sv
// Tile loader: gathers a row-major stream of 16 signed elements into a 4x4
// tile and presents it to the transform stage with a valid/ready handshake.
// Define PRETU_LOADER_DBUF_EN for two ping-pong banks; otherwise one bank.
// in_ready/out_valid depend only on the registered full-buffer count.
module pretu_tile_loader
    import pretu_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] X00,
    output logic [DW-1:0] X01,
    output logic [DW-1:0] X02,
    output logic [DW-1:0] X03,
    output logic [DW-1:0] X10,
    output logic [DW-1:0] X11,
    output logic [DW-1:0] X12,
    output logic [DW-1:0] X13,
    output logic [DW-1:0] X20,
    output logic [DW-1:0] X21,
    output logic [DW-1:0] X22,
    output logic [DW-1:0] X23,
    output logic [DW-1:0] X30,
    output logic [DW-1:0] X31,
    output logic [DW-1:0] X32,
    output logic [DW-1:0] X33,
    output logic          err_align
);

`ifdef PRETU_LOADER_DBUF_EN
    localparam logic [1:0] NBUF = 2'd2;
`else
    localparam logic [1:0] NBUF = 2'd1;
`endif

    logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     accept, at_last, complete, retire;
    logic [TILE_ELEMS*DW-1:0] rd_tile;

    assign in_ready  = (cnt_q < NBUF);
    assign out_valid = (cnt_q != 2'd0);
    assign err_align = err_q;

    // Handshake decode, fill index, framing error and full-count next state.
    always_comb begin
        accept   = in_valid && in_ready;
        at_last  = (wr_idx_q == IDX_LAST);
        complete = accept && at_last;
        retire   = out_valid && out_ready;
        wr_idx_d = wr_idx_q;
        err_d    = err_q;
        if (accept) begin
            if (at_last) begin
                // A tile always completes at index 15, even without in_last.
                wr_idx_d = '0;
                if (!in_last) begin
                    err_d = 1'b1;
                end
            end else if (in_last) begin
                // Early in_last: drop the partial tile and restart the fill.
                wr_idx_d = '0;
                err_d    = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end
        cnt_d = cnt_q + {1'b0, complete} - {1'b0, retire};
    end

    // Fill index, full-buffer count and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef PRETU_LOADER_DBUF_EN
    logic                     wr_sel_q, wr_sel_d;
    logic                     rd_sel_q, rd_sel_d;
    logic [TILE_ELEMS*DW-1:0] bank0_tile, bank1_tile;

    // Fill target flips on completion, read target flips on retire.
    always_comb begin
        wr_sel_d = wr_sel_q ^ complete;
        rd_sel_d = rd_sel_q ^ retire;
    end

    // Ping-pong bank selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    pretu_tile_reg #(.DW(DW)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept && !wr_sel_q),
        .waddr_i (wr_idx_q),
        .wdata_i (in_data),
        .tile_o  (bank0_tile)
    );

    pretu_tile_reg #(.DW(DW)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept && wr_sel_q),
        .waddr_i (wr_idx_q),
        .wdata_i (in_data),
        .tile_o  (bank1_tile)
    );

    assign rd_tile = rd_sel_q ? bank1_tile : bank0_tile;
`else
    // Single bank: filling is blocked by in_ready while the tile is presented.
    pretu_tile_reg #(.DW(DW)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (accept),
        .waddr_i (wr_idx_q),
        .wdata_i (in_data),
        .tile_o  (rd_tile)
    );
`endif

    assign X00 = rd_tile[ 0*DW +: DW];
    assign X01 = rd_tile[ 1*DW +: DW];
    assign X02 = rd_tile[ 2*DW +: DW];
    assign X03 = rd_tile[ 3*DW +: DW];
    assign X10 = rd_tile[ 4*DW +: DW];
    assign X11 = rd_tile[ 5*DW +: DW];
    assign X12 = rd_tile[ 6*DW +: DW];
    assign X13 = rd_tile[ 7*DW +: DW];
    assign X20 = rd_tile[ 8*DW +: DW];
    assign X21 = rd_tile[ 9*DW +: DW];
    assign X22 = rd_tile[10*DW +: DW];
    assign X23 = rd_tile[11*DW +: DW];
    assign X30 = rd_tile[12*DW +: DW];
    assign X31 = rd_tile[13*DW +: DW];
    assign X32 = rd_tile[14*DW +: DW];
    assign X33 = rd_tile[15*DW +: DW];

endmodule
